// File: rtl/cog_pkg.sv
// Shared widths, FIFO entry layout and FSM state encoding for the centroid divider.
package cog_pkg;

    localparam int COORD_W        = 11;
    localparam int SUM_IC_W       = 30;
    localparam int SUM_I_W        = 23;
    localparam int FRAC_BITS      = 4;
    localparam int COG_FIFO_DEPTH = 16;

    // Quotient / centroid width and the divider step counter width.
    localparam int QW    = COORD_W + FRAC_BITS;
    localparam int CNT_W = $clog2(QW);

    // One FIFO entry: a point (sums + start) and/or line/frame markers.
    typedef struct packed {
        logic                pt_vld;
        logic [SUM_IC_W-1:0] sum_ic;
        logic [SUM_I_W-1:0]  sum_i;
        logic [COORD_W-1:0]  start;
        logic                eol;
        logic                eof;
        logic                sof;
    } cog_event_t;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DIV,
        EMIT
    } cog_div_state_t;

endpackage

// File: rtl/cog_event_fifo.sv
// Event FIFO with a registered head. The head register counts toward the
// DEPTH entries of capacity; a read in the same cycle as a write while full
// makes room for that write.
module cog_event_fifo
    import cog_pkg::*;
#(
    parameter int DEPTH = COG_FIFO_DEPTH
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_i,
    input  cog_event_t wr_data_i,
    input  logic       rd_i,
    output cog_event_t head_o,
    output logic       empty_o,
    output logic       drop_o
);

    localparam int AW = $clog2(DEPTH);

    cog_event_t    mem_q [DEPTH];
    cog_event_t    head_q;
    logic          head_vld_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full;
    logic          wr_ok;
    logic          mem_empty;
    logic          refill;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign wr_ok     = wr_i && (!full || rd_i);
    assign drop_o    = wr_i && !wr_ok;
    // With the head valid the array holds at most DEPTH-1, so pointer equality means empty.
    assign mem_empty = (rd_ptr_q == wr_ptr_q);
    assign refill    = (!head_vld_q || rd_i) && !mem_empty;
    assign head_o    = head_q;
    assign empty_o   = !head_vld_q;

    // Occupancy including the head register.
    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array, no reset needed: contents are only read behind the pointers.
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Pointers, occupancy and head refill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (refill) begin
                head_q     <= mem_q[rd_ptr_q];
                head_vld_q <= 1'b1;
                rd_ptr_q   <= rd_ptr_q + AW'(1);
            end else if (rd_i) begin
                head_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cog_centroid_divider.sv
// Turns per-figure sums into a Q(COORD_W.FRAC_BITS) centroid with a
// restoring divider, keeping line/frame markers in order with the points.
module cog_centroid_divider
    import cog_pkg::*;
#(
    parameter int FIFO_DEPTH = COG_FIFO_DEPTH
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_reset,
    input  logic [SUM_IC_W-1:0] i_sum_of_I_mult_coord,
    input  logic [SUM_I_W-1:0]  i_sum_of_I,
    input  logic [COORD_W-1:0]  i_start_point,
    input  logic                i_point_is_valid,
    input  logic                i_end_of_line_delayed,
    input  logic                i_end_of_frame_delayed,
    input  logic                i_new_frame_delayed,
    output logic [QW-1:0]       o_centroid_reg,
    output logic                o_centroid_valid_reg,
    output logic                o_end_of_line_reg,
    output logic                o_end_of_frame_reg,
    output logic                o_new_frame_reg,
    output logic                o_div_by_zero_reg,
    output logic                o_saturated_reg,
    output logic                o_overflow_sticky
);

    localparam int CMP_W = SUM_I_W + COORD_W;

    cog_event_t     wr_ev, head;
    logic           fifo_wr, fifo_rd, fifo_empty, fifo_drop;
    cog_div_state_t state_q, state_d;

    // Latched entry and divider working registers.
    logic                 pt_q, pt_d;
    logic [SUM_I_W-1:0]   dvs_q, dvs_d;
    logic [COORD_W-1:0]   start_q, start_d;
    logic [2:0]           mrk_q, mrk_d;
    logic                 dbz_q, dbz_d, sat_q, sat_d;
    logic [SUM_I_W:0]     rem_q, rem_d;
    logic [QW-1:0]        dvd_q, dvd_d, quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Output registers.
    logic [QW-1:0] cent_q, cent_d;
    logic          cvld_q, cvld_d, eol_q, eol_d, eof_q, eof_d, sof_q, sof_d;
    logic          dz_q, dz_d, so_q, so_d, ovf_q, ovf_d;

    logic [SUM_I_W+1:0] trial;
    logic [SUM_I_W+1:0] dvs_ext;
    logic [QW:0]        sum_ext;
    logic               sat_cmp;

    assign fifo_wr = i_point_is_valid | i_end_of_line_delayed |
                     i_end_of_frame_delayed | i_new_frame_delayed;
    assign wr_ev   = '{pt_vld: i_point_is_valid, sum_ic: i_sum_of_I_mult_coord,
                       sum_i: i_sum_of_I, start: i_start_point,
                       eol: i_end_of_line_delayed, eof: i_end_of_frame_delayed,
                       sof: i_new_frame_delayed};

    cog_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (i_sys_clk),
        .rst_i     (i_sys_reset),
        .wr_i      (fifo_wr),
        .wr_data_i (wr_ev),
        .rd_i      (fifo_rd),
        .head_o    (head),
        .empty_o   (fifo_empty),
        .drop_o    (fifo_drop)
    );

    // Quotient would not fit in QW bits when sum_IC >= sum_I * 2^COORD_W.
    assign sat_cmp = CMP_W'(head.sum_ic) >= {head.sum_i, {COORD_W{1'b0}}};
    assign trial   = {rem_q, dvd_q[QW-1]};
    assign dvs_ext = (SUM_I_W+2)'(dvs_q);
    assign sum_ext = {1'b0, start_q, {FRAC_BITS{1'b0}}} + {1'b0, quo_q};

    // Next-state, divider step and output pulse generation.
    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        pt_d    = pt_q;
        dvs_d   = dvs_q;
        start_d = start_q;
        mrk_d   = mrk_q;
        dbz_d   = dbz_q;
        sat_d   = sat_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        cent_d  = '0;
        cvld_d  = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;
        sof_d   = 1'b0;
        dz_d    = 1'b0;
        so_d    = 1'b0;
        ovf_d   = ovf_q | fifo_drop;
        case (state_q)
            IDLE: if (!fifo_empty) state_d = POP;
            POP: begin
                fifo_rd = 1'b1;
                pt_d    = head.pt_vld;
                dvs_d   = head.sum_i;
                start_d = head.start;
                mrk_d   = {head.eol, head.eof, head.sof};
                dbz_d   = 1'b0;
                sat_d   = 1'b0;
                quo_d   = '0;
                cnt_d   = '0;
                state_d = EMIT;
                if (head.pt_vld) begin
                    if (head.sum_i == '0) begin
                        dbz_d = 1'b1;
                    end else if (sat_cmp) begin
                        sat_d = 1'b1;
                        quo_d = '1;
                    end else begin
                        // Dividend sum_IC<<FRAC_BITS: the upper part seeds the
                        // remainder, the low QW bits are shifted in one per step.
                        rem_d   = (SUM_I_W+1)'(head.sum_ic >> COORD_W);
                        dvd_d   = {head.sum_ic[COORD_W-1:0], {FRAC_BITS{1'b0}}};
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (trial >= dvs_ext) begin
                    rem_d = (SUM_I_W+1)'(trial - dvs_ext);
                    quo_d = {quo_q[QW-2:0], 1'b1};
                end else begin
                    rem_d = (SUM_I_W+1)'(trial);
                    quo_d = {quo_q[QW-2:0], 1'b0};
                end
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(QW-1)) state_d = EMIT;
            end
            EMIT: begin
                if (pt_q && !dbz_q) begin
                    cvld_d = 1'b1;
                    cent_d = sum_ext[QW] ? '1 : sum_ext[QW-1:0];
                    so_d   = sat_q | sum_ext[QW];
                end
                dz_d    = pt_q & dbz_q;
                eol_d   = mrk_q[2];
                eof_d   = mrk_q[1];
                sof_d   = mrk_q[0];
                state_d = fifo_empty ? IDLE : POP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Datapath and output registers; reset abandons any division in flight.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            pt_q    <= 1'b0;
            dvs_q   <= '0;
            start_q <= '0;
            mrk_q   <= '0;
            dbz_q   <= 1'b0;
            sat_q   <= 1'b0;
            rem_q   <= '0;
            dvd_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            cent_q  <= '0;
            cvld_q  <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            sof_q   <= 1'b0;
            dz_q    <= 1'b0;
            so_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pt_q    <= pt_d;
            dvs_q   <= dvs_d;
            start_q <= start_d;
            mrk_q   <= mrk_d;
            dbz_q   <= dbz_d;
            sat_q   <= sat_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            cent_q  <= cent_d;
            cvld_q  <= cvld_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            sof_q   <= sof_d;
            dz_q    <= dz_d;
            so_q    <= so_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_centroid_reg       = cent_q;
    assign o_centroid_valid_reg = cvld_q;
    assign o_end_of_line_reg    = eol_q;
    assign o_end_of_frame_reg   = eof_q;
    assign o_new_frame_reg      = sof_q;
    assign o_div_by_zero_reg    = dz_q;
    assign o_saturated_reg      = so_q;
    assign o_overflow_sticky    = ovf_q;

endmodule

// File: tb/tb_cog_centroid_divider.sv
// Scoreboard bench for cog_centroid_divider: stimulus pushes expected output
// events, a negedge monitor pops and compares whenever any output pulses.
module tb_cog_centroid_divider;
    import cog_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [SUM_IC_W-1:0] sic;
    logic [SUM_I_W-1:0]  si;
    logic [COORD_W-1:0]  st;
    logic                pv, eol, eof, sof;
    logic [QW-1:0]       o_cent;
    logic                o_vld, o_eol, o_eof, o_sof, o_dz, o_sat, o_ovf;

    always #5 clk = ~clk;

    cog_centroid_divider dut (
        .i_sys_clk              (clk),
        .i_sys_reset            (rst),
        .i_sum_of_I_mult_coord  (sic),
        .i_sum_of_I             (si),
        .i_start_point          (st),
        .i_point_is_valid       (pv),
        .i_end_of_line_delayed  (eol),
        .i_end_of_frame_delayed (eof),
        .i_new_frame_delayed    (sof),
        .o_centroid_reg         (o_cent),
        .o_centroid_valid_reg   (o_vld),
        .o_end_of_line_reg      (o_eol),
        .o_end_of_frame_reg     (o_eof),
        .o_new_frame_reg        (o_sof),
        .o_div_by_zero_reg      (o_dz),
        .o_saturated_reg        (o_sat),
        .o_overflow_sticky      (o_ovf)
    );

    typedef struct packed {
        logic          vld;
        logic [QW-1:0] cent;
        logic          sat;
        logic          dbz;
        logic          eol;
        logic          eof;
        logic          sof;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    cyc_q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic obs_t mk(input logic v, input int c, input logic s, input logic z,
                                input logic e, input logic f, input logic n);
        obs_t o;
        o = '{vld: v, cent: QW'(c), sat: s, dbz: z, eol: e, eof: f, sof: n};
        return o;
    endfunction

    task automatic expect_ev(input obs_t o, input string tag, input int c);
        exp_q.push_back(o);
        tag_q.push_back(tag);
        cyc_q.push_back(c);
    endtask

    task automatic drive(input logic p, input int ic_v, input int si_v, input int st_v,
                         input logic e, input logic f, input logic n);
        @(posedge clk); #1;
        pv  = p;
        sic = SUM_IC_W'(ic_v);
        si  = SUM_I_W'(si_v);
        st  = COORD_W'(st_v);
        eol = e;
        eof = f;
        sof = n;
        last_cyc = cyc;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        pv = 1'b0; sic = '0; si = '0; st = '0; eol = 1'b0; eof = 1'b0; sof = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    // Monitor: every cycle with any output pulse consumes one expected event.
    obs_t  m_act, m_exp;
    string m_tag;
    int    m_cyc;
    always @(negedge clk) begin
        if (o_vld || o_eol || o_eof || o_sof || o_dz || o_sat) begin
            m_act = {o_vld, o_cent, o_sat, o_dz, o_eol, o_eof, o_sof};
            if (!m_act.vld) m_act.cent = '0;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(m_act), 64'd0);
            end else begin
                m_exp = exp_q.pop_front();
                m_tag = tag_q.pop_front();
                m_cyc = cyc_q.pop_front();
                chk(m_tag, 64'(m_act), 64'(m_exp));
                if (m_cyc >= 0) chk({m_tag, "_cycle"}, 64'(cyc), 64'(m_cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        pv = 1'b0; sic = '0; si = '0; st = '0; eol = 1'b0; eof = 1'b0; sof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({o_vld, o_cent, o_eol, o_eof, o_sof, o_dz, o_sat}), 64'd0);
        chk("reset_sticky", 64'(o_ovf), 64'd0);
        rst = 1'b0;

        // Write at cycle N: head ready N+2, POP N+3, 15 DIV, EMIT N+19, output N+20.
        drive(1, 30, 10, 5, 0, 0, 0);
        expect_ev(mk(1, 128, 0, 0, 0, 0, 0), "int_8p0", last_cyc + 20);
        idle();
        wait_drain("int", 60);

        drive(1, 7, 2, 0, 0, 0, 0);
        expect_ev(mk(1, 56, 0, 0, 0, 0, 0), "frac_3p5", last_cyc + 20);
        idle();
        wait_drain("frac_a", 60);

        drive(1, 1, 3, 0, 0, 0, 0);
        expect_ev(mk(1, 5, 0, 0, 0, 0, 0), "frac_trunc", last_cyc + 20);
        idle();
        wait_drain("frac_b", 60);

        // Degenerate cases take only POP + EMIT.
        drive(1, 123, 0, 7, 1, 0, 0);
        expect_ev(mk(0, 0, 0, 1, 1, 0, 0), "dbz_eol", last_cyc + 5);
        idle();
        wait_drain("dbz", 60);

        drive(1, 40000, 1, 0, 0, 0, 0);
        expect_ev(mk(1, 32767, 1, 0, 0, 0, 0), "q_sat", last_cyc + 5);
        idle();
        wait_drain("qsat", 60);

        // 2047.0 + 1.0 carries out of QW bits.
        drive(1, 1, 1, 2047, 0, 0, 0);
        expect_ev(mk(1, 32767, 1, 0, 0, 0, 0), "add_carry", last_cyc + 20);
        idle();
        wait_drain("carry", 60);

        // Ordering: A, EOL, B, EOF, SOF on consecutive cycles.
        drive(1, 30, 10, 5, 0, 0, 0);
        base = last_cyc;
        expect_ev(mk(1, 128, 0, 0, 0, 0, 0), "ord_A", base + 20);
        drive(0, 0, 0, 0, 1, 0, 0);
        expect_ev(mk(0, 0, 0, 0, 1, 0, 0), "ord_EOL", base + 22);
        drive(1, 7, 2, 0, 0, 0, 0);
        expect_ev(mk(1, 56, 0, 0, 0, 0, 0), "ord_B", base + 39);
        drive(0, 0, 0, 0, 0, 1, 0);
        expect_ev(mk(0, 0, 0, 0, 0, 1, 0), "ord_EOF", base + 41);
        drive(0, 0, 0, 0, 0, 0, 1);
        expect_ev(mk(0, 0, 0, 0, 0, 0, 1), "ord_SOF", base + 43);
        idle();
        wait_drain("order", 100);

        // Overflow: 20 back-to-back points, the first 17 survive.
        base = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, i + 1, 1, i, 0, 0, 0);
            if (i == 0) base = last_cyc;
            if (i < 17) expect_ev(mk(1, 32 * i + 16, 0, 0, 0, 0, 0), "ovf_pt", base + 20 + 17 * i);
            if (i == 17) chk("ovf_sticky_before_drop", 64'(o_ovf), 64'd0);
        end
        idle();
        chk("ovf_sticky_set", 64'(o_ovf), 64'd1);
        wait_drain("ovf", 400);
        chk("ovf_sticky_hold", 64'(o_ovf), 64'd1);

        // Reset on the 8th DIV cycle: POP at N+3, DIV cycles N+4.., 8th is N+11.
        drive(1, 30, 10, 5, 0, 0, 0);
        idle();
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outputs", 64'({o_vld, o_cent, o_eol, o_eof, o_sof, o_dz, o_sat}), 64'd0);
        chk("rst_mid_sticky", 64'(o_ovf), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_quiet", 64'({o_vld, o_cent, o_eol, o_eof, o_sof, o_dz, o_sat}), 64'd0);
        chk("post_rst_sticky", 64'(o_ovf), 64'd0);

        drive(1, 7, 2, 0, 0, 0, 0);
        expect_ev(mk(1, 56, 0, 0, 0, 0, 0), "post_rst_pt", last_cyc + 20);
        idle();
        wait_drain("post_rst", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
